// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - UART serial boot loader that fills instruction memory and releases the CPU
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uartRx,
  output logic                  imemWe,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  output logic [31:0]           imemWData,
  output logic                  cpuRstN,
  output logic                  loadDone,
  output logic                  loadError
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      MAX_LEN = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE, LD_ERROR} ld_state_t;

  // ---------------- receiver ----------------
  logic [1:0]       rx_sync;
  logic             rx_s;
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_byte;
  logic             half_hit, full_hit;
  logic             cnt_clr, shift_en, stop_ok, stop_bad;
  logic             byte_valid, frame_err;

  assign rx_s     = rx_sync[1];
  assign half_hit = (rx_cnt == HALF_M1);
  assign full_hit = (rx_cnt == FULL_M1);

  // Two-flop synchronizer; resets to the idle line level so no false start is seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], uartRx};
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  // Receiver next state: mid-start re-check rejects glitches, stop returns straight to idle
  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (!rx_s) rx_next = RX_START;
      RX_START: if (half_hit) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_hit && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (full_hit) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Receiver strobes derived from state and bit-timer position
  always_comb begin
    cnt_clr  = (rx_state == RX_IDLE) || (rx_state == RX_START && half_hit) ||
               ((rx_state == RX_DATA || rx_state == RX_STOP) && full_hit);
    shift_en = (rx_state == RX_DATA) && full_hit;
    stop_ok  = (rx_state == RX_STOP) && full_hit && rx_s;
    stop_bad = (rx_state == RX_STOP) && full_hit && !rx_s;
  end

  // Bit timer, LSB-first shift register and one-cycle byte/error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_cnt     <= cnt_clr ? '0 : rx_cnt + 1'b1;
      byte_valid <= stop_ok;
      frame_err  <= stop_bad;
      if (shift_en) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
        rx_bit  <= rx_bit + 1'b1;
      end else if (rx_state == RX_IDLE) begin
        rx_bit <= '0;
      end
    end
  end

  // ---------------- loader ----------------
  ld_state_t        ld_state, ld_next;
  logic [7:0]       len_lo;
  logic [15:0]      len;
  logic [15:0]      len_full;
  logic [IDX_W-1:0] word_idx, idx_inc;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic             last_word, word_write;

  assign len_full  = {rx_byte, len_lo};
  assign idx_inc   = word_idx + 1'b1;
  assign last_word = (17'(idx_inc) == {1'b0, len});

  // Loader state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ld_state <= LD_LEN_LO;
    else      ld_state <= ld_next;
  end

  // Loader next state: a framing error is fatal everywhere except after completion
  always_comb begin
    ld_next = ld_state;
    unique case (ld_state)
      LD_LEN_LO: begin
        if (frame_err)       ld_next = LD_ERROR;
        else if (byte_valid) ld_next = LD_LEN_HI;
      end
      LD_LEN_HI: begin
        if (frame_err) ld_next = LD_ERROR;
        else if (byte_valid) begin
          if (len_full == 16'd0)               ld_next = LD_DONE;
          else if ({1'b0, len_full} > MAX_LEN) ld_next = LD_ERROR;
          else                                 ld_next = LD_DATA;
        end
      end
      LD_DATA: begin
        if (frame_err) ld_next = LD_ERROR;
        else if (byte_valid && byte_cnt == 2'd3 && last_word) ld_next = LD_DONE;
      end
      LD_DONE:  ld_next = LD_DONE;
      LD_ERROR: ld_next = LD_ERROR;
      default:  ld_next = LD_ERROR;
    endcase
  end

  // Loader status outputs and the write decision
  always_comb begin
    loadDone   = (ld_state == LD_DONE);
    loadError  = (ld_state == LD_ERROR);
    word_write = (ld_state == LD_DATA) && byte_valid && (byte_cnt == 2'd3);
  end

  // Length capture, little-endian word assembly and registered memory write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo    <= '0;
      len       <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      word_buf  <= '0;
      imemWe    <= 1'b0;
      imemAddr  <= '0;
      imemWData <= '0;
      cpuRstN   <= 1'b0;
    end else begin
      imemWe  <= word_write;
      cpuRstN <= (ld_state == LD_DONE);
      if (ld_state == LD_LEN_LO && byte_valid) len_lo <= rx_byte;
      if (ld_state == LD_LEN_HI && byte_valid) len <= len_full;
      if (ld_state == LD_DATA && byte_valid) begin
        byte_cnt <= byte_cnt + 1'b1;
        unique case (byte_cnt)
          2'd0: word_buf[7:0]   <= rx_byte;
          2'd1: word_buf[15:8]  <= rx_byte;
          2'd2: word_buf[23:16] <= rx_byte;
          default: begin
            imemWData <= {rx_byte, word_buf};
            imemAddr  <= word_idx[ADDR_WIDTH-1:0];
            word_idx  <= idx_inc;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - self-checking bench for uart_imem_loader
module tb_uart_imem_loader;

  localparam int CPB = 4;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          uartRx = 1'b1;
  logic          imemWe;
  logic [AW-1:0] imemAddr;
  logic [31:0]   imemWData;
  logic          cpuRstN;
  logic          loadDone;
  logic          loadError;

  always #5 clk = ~clk;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .uartRx(uartRx),
    .imemWe(imemWe), .imemAddr(imemAddr), .imemWData(imemWData),
    .cpuRstN(cpuRstN), .loadDone(loadDone), .loadError(loadError)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Write monitor, sampled on the falling edge
  logic [AW-1:0] act_addr[$];
  logic [31:0]   act_data[$];
  int            cyc = 0;
  int            last_we_cyc = -1;
  int            cpu_rise_cyc = -1;
  logic          prev_cpu = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (imemWe === 1'b1) begin
        act_addr.push_back(imemAddr);
        act_data.push_back(imemWData);
        last_we_cyc = cyc;
      end
      if (cpuRstN === 1'b1 && prev_cpu !== 1'b1) cpu_rise_cyc = cyc;
      prev_cpu = cpuRstN;
    end
  end

  // Byte stream and reference model
  logic [7:0]    tx_b[$];
  bit            tx_ok[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  bit            exp_done, exp_err;

  task automatic build(input int len, input int nwords, input logic [31:0] first,
                       input logic [31:0] last, input int bad);
    logic [15:0] l16;
    logic [31:0] w;
    tx_b.delete();
    tx_ok.delete();
    l16 = len[15:0];
    tx_b.push_back(l16[7:0]);
    tx_b.push_back(l16[15:8]);
    for (int j = 0; j < nwords; j++) begin
      if (j == 0) w = first;
      else if (j == nwords - 1) w = last;
      else w = $urandom();
      for (int k = 0; k < 4; k++) tx_b.push_back(w[8*k +: 8]);
    end
    for (int i = 0; i < tx_b.size(); i++) tx_ok.push_back(i != bad);
  endtask

  // phase: 0 len low, 1 len high, 2 words, 3 done, 4 error
  task automatic model();
    int phase = 0;
    int len = 0;
    int idx = 0;
    int k = 0;
    logic [31:0] w = 0;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < tx_b.size(); i++) begin
      if (phase >= 3) continue;
      if (!tx_ok[i]) begin
        phase = 4;
        continue;
      end
      case (phase)
        0: begin
          len = int'(tx_b[i]);
          phase = 1;
        end
        1: begin
          len = len + int'(tx_b[i]) * 256;
          if (len == 0) phase = 3;
          else if (len > (1 << AW)) phase = 4;
          else phase = 2;
        end
        default: begin
          w = w | (32'(tx_b[i]) << (8 * k));
          k++;
          if (k == 4) begin
            exp_addr.push_back(idx[AW-1:0]);
            exp_data.push_back(w);
            idx++;
            k = 0;
            w = 0;
            if (idx == len) phase = 3;
          end
        end
      endcase
    end
    exp_done = (phase == 3);
    exp_err  = (phase == 4);
  endtask

  task automatic hold(input logic v);
    uartRx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    hold(1'b0);
    for (int i = 0; i < 8; i++) hold(b[i]);
    hold(ok);
    if (!ok) hold(1'b1);
  endtask

  task automatic clear_mon();
    act_addr.delete();
    act_data.delete();
    last_we_cyc  = -1;
    cpu_rise_cyc = -1;
  endtask

  task automatic do_reset();
    uartRx = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_mon();
  endtask

  task automatic run_stream(input bit glitch);
    @(posedge clk);
    #1;
    if (glitch) begin
      uartRx = 1'b0;
      @(posedge clk);
      #1;
      uartRx = 1'b1;
      repeat (10) @(posedge clk);
      #1;
    end
    for (int i = 0; i < tx_b.size(); i++) send_byte(tx_b[i], tx_ok[i]);
    uartRx = 1'b1;
    repeat (20 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    int n;
    check({tag, " write count"}, act_addr.size(), exp_addr.size());
    n = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s addr[%0d]", tag, i), 32'(act_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s data[%0d]", tag, i), act_data[i], exp_data[i]);
    end
    check({tag, " loadDone"}, loadDone, exp_done);
    check({tag, " loadError"}, loadError, exp_err);
    check({tag, " cpuRstN"}, cpuRstN, exp_done);
    if (exp_done && exp_addr.size() > 0)
      check({tag, " cpuRstN rise"}, cpu_rise_cyc, last_we_cyc + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " imemWe"}, imemWe, 1'b0);
    check({tag, " imemAddr"}, 32'(imemAddr), 32'd0);
    check({tag, " imemWData"}, imemWData, 32'd0);
    check({tag, " cpuRstN"}, cpuRstN, 1'b0);
    check({tag, " loadDone"}, loadDone, 1'b0);
    check({tag, " loadError"}, loadError, 1'b0);
  endtask

  typedef struct {
    int          len;
    int          nwords;
    logic [31:0] first;
    logic [31:0] last;
    int          bad;
    bit          glitch;
    int          exp_n;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{7,       7, 32'h001000B7, 32'hFE9FF1EF, -1, 1'b0, 7, 1'b1, 1'b0};
    tbl[1] = '{0,       1, 32'hDDCCBBAA, 32'hDDCCBBAA, -1, 1'b0, 0, 1'b1, 1'b0};
    tbl[2] = '{1025,    0, 32'h0,        32'h0,        -1, 1'b0, 0, 1'b0, 1'b1};
    tbl[3] = '{2,       2, 32'h44332211, 32'h88776655,  4, 1'b0, 0, 1'b0, 1'b1};
    tbl[4] = '{1,       1, 32'h12345678, 32'h12345678, -1, 1'b1, 1, 1'b1, 1'b0};
    tbl[5] = '{16'hFFFF,0, 32'h0,        32'h0,        -1, 1'b0, 0, 1'b0, 1'b1};
    tbl[6] = '{3,       3, 32'hA5A5A5A5, 32'h5A5A5A5A,  0, 1'b0, 0, 1'b0, 1'b1};
    tbl[7] = '{3,       3, 32'h01020304, 32'h0A0B0C0D, 13, 1'b0, 2, 1'b0, 1'b1};
    tbl[8] = '{2,       3, 32'hDEADBEEF, 32'h0BADF00D, -1, 1'b0, 2, 1'b1, 1'b0};

    #1;
    check_reset_outputs("por");

    for (int t = 0; t < 9; t++) begin
      string tag;
      tag = $sformatf("vec%0d", t);
      do_reset();
      build(tbl[t].len, tbl[t].nwords, tbl[t].first, tbl[t].last, tbl[t].bad);
      model();
      run_stream(tbl[t].glitch);
      check({tag, " table count"}, act_addr.size(), tbl[t].exp_n);
      check({tag, " table done"}, loadDone, tbl[t].exp_done);
      check({tag, " table error"}, loadError, tbl[t].exp_err);
      compare_model(tag);
    end

    for (int r = 0; r < 5; r++) begin
      int len, nw, bad;
      len = $urandom_range(1, 4);
      nw  = len + $urandom_range(0, 1);
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 + 4 * nw - 1)) : -1;
      do_reset();
      build(len, nw, $urandom(), $urandom(), bad);
      model();
      run_stream(1'b0);
      compare_model($sformatf("rand%0d", r));
    end

    // Reset in the middle of the second word, then a fresh single-word load
    do_reset();
    build(2, 2, 32'h11223344, 32'h55667788, -1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send_byte(tx_b[i], 1'b1);
    repeat (4 * CPB) @(posedge clk);
    #1;
    check("midrst first write count", act_addr.size(), 1);
    check("midrst busy loadDone", loadDone, 1'b0);
    #3;
    rst = 1'b0;
    #2;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_mon();
    build(1, 1, 32'hCAFEF00D, 32'hCAFEF00D, -1);
    model();
    run_stream(1'b0);
    compare_model("midrst reload");
    if (act_data.size() > 0) check("midrst reload word", act_data[0], 32'hCAFEF00D);
    else check("midrst reload word present", act_data.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Serial boot loader that writes the CPU instruction memory over a UART.
- In simulation, instruction memory is preloaded directly; this block is the hardware writer for the FPGA build.
- Receives a length-prefixed little-endian word stream on `uartRx` and writes each word into instruction memory.
- Holds the CPU in reset until the load completes; on a bad stream, reports an error and keeps the CPU held.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); must be >= 4.
- ADDR_WIDTH, 10, instruction memory word-address width (1024 words).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- uartRx  input  1  UART serial input, idle high, 8N1, LSB first
- imemWe  output  1  instruction memory write strobe, one-cycle pulse per word
- imemAddr  output  ADDR_WIDTH  word address of the write
- imemWData  output  32  write data
- cpuRstN  output  1  active-low CPU reset; low until the load completes
- loadDone  output  1  high once all words are written; sticky until rst
- loadError  output  1  high on a framing or length error; sticky until rst

Behaviour:
- **Reset (rst low, asynchronous):**
  - imemWe=0, imemAddr=0, imemWData=0, cpuRstN=0, loadDone=0, loadError=0.
  - All counters cleared; both FSMs go to their first state.
  - Memory contents are not touched.
- **Input sync:** uartRx passes through a 2-flop synchronizer; the flops reset to 1.
- **RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.**
  - IDLE: a synchronized 0 starts the bit counter and moves to START.
  - START: at CLKS_PER_BIT/2 the line is re-sampled.
    - Line 1: treated as a glitch; return to IDLE, no byte produced.
    - Line 0: go to DATA.
  - DATA: 8 samples taken every CLKS_PER_BIT, LSB first.
  - STOP: one sample after a further CLKS_PER_BIT.
    - 1: raise byteValid (internal) for one cycle.
    - 0: raise frameErr (internal) for one cycle.
  - After STOP, return to IDLE immediately; the next start edge may arrive at once.
- **Loader FSM: LEN_LO -> LEN_HI -> DATA -> DONE, or ERROR.**
  - LEN_LO: byte becomes len[7:0].
  - LEN_HI: byte becomes len[15:8]. Then:
    - len == 0 -> DONE.
    - len > 2^ADDR_WIDTH -> ERROR.
    - otherwise -> DATA.
  - DATA: bytes are assembled little-endian (byte 0 -> bits [7:0] ... byte 3 -> bits [31:24]).
    - On the 4th byte, the cycle after byteValid: imemWe=1 for exactly one cycle, with imemAddr = word index and imemWData = assembled word.
    - The word index increments after the write.
    - When index reaches len, go to DONE in the same cycle as the last write.
  - DONE: loadDone=1; cpuRstN goes high one cycle after DONE is entered (registered). Further RX bytes are ignored; no writes occur.
  - ERROR: entered on frameErr in any loader state except DONE.
    - loadError=1, cpuRstN stays 0, no further writes.
    - Exit only via rst.
- **Holding values:** imemAddr and imemWData hold their last values between writes. imemAddr never exceeds 2^ADDR_WIDTH-1.
- **Simultaneous events:** byteValid and frameErr are mutually exclusive by construction. A frameErr in DONE is ignored.
- **Reset mid-load:** the partial word is discarded. The next load restarts at LEN_LO and address 0.
- **Latency:** the write strobe comes 1 cycle after the stop-bit sample of the word's 4th byte.

Test Plan (CLKS_PER_BIT=4, ADDR_WIDTH=10):
1. **Full load.**
   - Stimulus: bytes 07 00, then the 7 words LSB first; word 0 = 0x001000B7, word 6 = 0xFE9FF1EF.
   - Required: exactly 7 imemWe pulses at addr 0..6; addr 0 data = 0x001000B7, addr 6 data = 0xFE9FF1EF; loadDone=1; cpuRstN rises 1 cycle after the last pulse.
2. **Zero length.**
   - Stimulus: bytes 00 00, then bytes AA BB CC DD.
   - Required: no imemWe pulses; loadDone=1 after the 2nd byte; cpuRstN=1; the trailing bytes cause no writes.
3. **Oversize length.**
   - Stimulus: bytes 01 04 (len=1025).
   - Required: loadError=1 after the 2nd byte; no writes; cpuRstN=0; loadDone=0.
4. **Framing error.**
   - Stimulus: bytes 02 00 11 22, then a byte 33 sent with stop bit 0.
   - Required: loadError=1; no imemWe pulse ever; later valid bytes ignored.
5. **Glitch rejection.**
   - Stimulus: uartRx low for 1 clk while idle, then a valid load of 1 word 0x12345678.
   - Required: no spurious byte; single write at addr 0 with data 0x12345678; loadDone=1.
6. **Reset mid-load.**
   - Stimulus: len=2; word 0 written; rst pulsed low after 2 bytes of word 1; then a fresh load of 1 word 0xCAFEF00D.
   - Required: outputs return to reset values while rst is low; the fresh load writes addr 0 = 0xCAFEF00D; loadDone=1.
